// File: rtl/ysyx_22050019_ifu.sv
// rtl/ysyx_22050019_ifu.sv - single-outstanding instruction fetch unit
// Request / wait / hold loop: one fetch in flight, the result is held for the IDU until it is consumed.
module ysyx_22050019_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  output logic [63:0] if_req_addr,
  input  logic        if_rsp_valid,
  output logic        if_rsp_ready,
  input  logic [31:0] if_rsp_data,
  input  logic        if_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic [63:0] inst_addr_pc,
  output logic        inst_fault,
  input  logic        inst_j,
  input  logic [63:0] snpc,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  logic [63:0] cnt_q, cnt_d;

  logic req_fire, rsp_fire, inst_fire;

  assign req_fire  = (state_q == S_REQ)  && if_req_ready;
  assign rsp_fire  = (state_q == S_WAIT) && if_rsp_valid;
  assign inst_fire = (state_q == S_HOLD) && inst_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (req_fire)  state_d = S_WAIT;
      S_WAIT:  if (rsp_fire)  state_d = S_HOLD;
      S_HOLD:  if (inst_fire) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    if_req_valid  = 1'b0;
    if_rsp_ready  = 1'b0;
    inst_valid    = 1'b0;
    case (state_q)
      S_REQ:   if_req_valid = 1'b1;
      S_WAIT:  if_rsp_ready = 1'b1;
      S_HOLD:  inst_valid   = 1'b1;
      default: ;
    endcase
  end

  // Redirect target is word-aligned here so the request address never needs a separate mask path.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    if (rsp_fire) begin
      inst_d  = if_rsp_data;
      fault_d = if_rsp_err;
    end
    if (inst_fire) begin
      pc_d  = inst_j ? (snpc & ~64'h3) : (pc_q + 64'd4);
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      fault_q <= 1'b0;
      cnt_q   <= 64'd0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign if_req_addr  = {pc_q[63:2], 2'b00};
  assign inst_o       = inst_q;
  assign inst_addr_pc = pc_q;
  assign inst_fault   = fault_q;
  assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// tb/tb_ysyx_22050019_ifu.sv - directed vector bench for the fetch unit
// Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_ysyx_22050019_ifu;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_pc;
  logic        inst_fault;
  logic        inst_j;
  logic [63:0] snpc;
  logic [63:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  ysyx_22050019_ifu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_o       (inst_o),
    .inst_addr_pc (inst_addr_pc),
    .inst_fault   (inst_fault),
    .inst_j       (inst_j),
    .snpc         (snpc),
    .fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        j;
    logic [63:0] target;
    logic [63:0] exp_addr;
    logic [63:0] exp_next;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle and land 1ns after the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input vec_t v, input logic [63:0] exp_cnt);
    chk("req_valid", {63'd0, if_req_valid}, 64'd1);
    chk("req_addr", if_req_addr, v.exp_addr);
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    chk("wait_rsp_ready", {63'd0, if_rsp_ready}, 64'd1);
    chk("wait_req_valid", {63'd0, if_req_valid}, 64'd0);
    if_rsp_valid = 1'b1;
    if_rsp_data  = v.data;
    if_rsp_err   = v.err;
    step();
    if_rsp_valid = 1'b0;
    if_rsp_err   = 1'b0;
    chk("hold_valid", {63'd0, inst_valid}, 64'd1);
    chk("hold_inst", {32'd0, inst_o}, {32'd0, v.data});
    chk("hold_pc", inst_addr_pc, v.exp_addr);
    chk("hold_fault", {63'd0, inst_fault}, {63'd0, v.err});
    inst_ready = 1'b1;
    inst_j     = v.j;
    snpc       = v.target;
    step();
    inst_ready = 1'b0;
    inst_j     = 1'b0;
    snpc       = 64'd0;
    chk("next_addr", if_req_addr, v.exp_next);
    chk("fetch_cnt", fetch_cnt, exp_cnt);
    chk("after_inst_valid", {63'd0, inst_valid}, 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; if_req_ready = 1'b0; if_rsp_valid = 1'b0; if_rsp_data = 32'd0;
    if_rsp_err = 1'b0; inst_ready = 1'b0; inst_j = 1'b0; snpc = 64'd0;

    vecs[0] = '{32'h0050_0093, 1'b0, 1'b0, 64'd0, 64'h8000_0000, 64'h8000_0004};
    vecs[1] = '{32'h0000_0013, 1'b1, 1'b0, 64'd0, 64'h8000_0004, 64'h8000_0008};
    vecs[2] = '{32'h1234_5678, 1'b0, 1'b1, 64'h8000_0102, 64'h8000_0008, 64'h8000_0100};
    vecs[3] = '{32'hAAAA_5555, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[4] = '{32'h0000_0000, 1'b0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    vecs[5] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0, 64'h0, 64'h4};

    step();
    step();
    rst_n = 1'b1;
    chk("rst_req_valid", {63'd0, if_req_valid}, 64'd1);
    chk("rst_req_addr", if_req_addr, 64'h8000_0000);
    chk("rst_inst", {32'd0, inst_o}, 64'h13);
    chk("rst_fault", {63'd0, inst_fault}, 64'd0);
    chk("rst_cnt", fetch_cnt, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_rsp_ready", {63'd0, if_rsp_ready}, 64'd0);

    for (int i = 0; i < 6; i++) fetch(vecs[i], 64'(i + 1));

    // Stray response and request backpressure while sitting in S_REQ at pc 4.
    if_rsp_valid = 1'b1;
    if_rsp_data  = 32'hBAD0_BAD0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_req_valid", {63'd0, if_req_valid}, 64'd1);
      chk("bp_req_addr", if_req_addr, 64'h4);
      chk("stray_inst", {32'd0, inst_o}, 64'hDEAD_BEEF);
      chk("stray_rsp_ready", {63'd0, if_rsp_ready}, 64'd0);
    end
    if_rsp_valid = 1'b0;
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    // A redirect pulsed while waiting must not move the pc.
    inst_j = 1'b1;
    snpc   = 64'h1000;
    step();
    inst_j = 1'b0;
    snpc   = 64'd0;
    chk("wait_still", {63'd0, if_rsp_ready}, 64'd1);
    if_rsp_valid = 1'b1;
    if_rsp_data  = 32'h0010_0073;
    step();
    if_rsp_valid = 1'b0;
    held = inst_o;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_inst_valid", {63'd0, inst_valid}, 64'd1);
      chk("bp_inst", {32'd0, inst_o}, 64'h0010_0073);
      chk("bp_pc", inst_addr_pc, 64'h4);
      chk("bp_no_req", {63'd0, if_req_valid}, 64'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("bp_next_addr", if_req_addr, 64'h8);
    chk("bp_cnt", fetch_cnt, 64'd7);

    // Reset while a request is outstanding; the late response must be dropped.
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    chk("pre_rst_wait", {63'd0, if_rsp_ready}, 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    if_rsp_valid = 1'b1;
    if_rsp_data  = 32'h5555_AAAA;
    chk("rstw_req_valid", {63'd0, if_req_valid}, 64'd1);
    chk("rstw_addr", if_req_addr, 64'h8000_0000);
    chk("rstw_cnt", fetch_cnt, 64'd0);
    chk("rstw_inst", {32'd0, inst_o}, 64'h13);
    step();
    if_rsp_valid = 1'b0;
    chk("stale_inst", {32'd0, inst_o}, 64'h13);
    chk("stale_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("stale_req_valid", {63'd0, if_req_valid}, 64'd1);
    chk("held_was_latched", {32'd0, held}, 64'h0010_0073);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
